// File: rtl/axi_sram_pkg.sv
// Shared encodings for the AXI3 SRAM responder: response codes, burst types
// and the transaction state machine.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WRESP
  } state_e;

  // Largest beat size the array can serve: 4 bytes.
  localparam logic [2:0] MAX_SIZE = 3'd2;

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for an AXI burst. WRAP steps like INCR; such bursts are
// always answered with SLVERR, so the exact sequence never reaches the array.
module axi_burst_addr
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  always_comb begin
    next_addr_o = addr_i;
    if (burst_i != BURST_FIXED) next_addr_o = addr_i + (ADDR_W'(1) << size_i);
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by an inferred word-addressed SRAM; one read or write
// transaction at a time, with AR/AW round-robin arbitration.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                LEN_W     = 8,
  parameter int                MEM_AW    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [1:0]          arlock,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [1:0]          awlock,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int              DEPTH = 1 << MEM_AW;
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(4) << MEM_AW;

  state_e              state_q, state_d;
  logic                prefer_rd_q, prefer_rd_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  resp_e               resp_q, resp_d;
  logic                wlast_err_q, wlast_err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   next_addr, rd_addr;
  logic [DATA_W-1:0]   rd_word;
  logic                last_beat, mem_we;
  logic                unused_ok;

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // A start address below the base borrows into the top bit, which also
  // lands at or above SPAN, so one compare covers both ends of the window.
  function automatic resp_e accept_resp(input logic [ADDR_W-1:0] a,
                                        input logic [2:0] sz, input logic [1:0] bu);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    if (off >= SPAN) return RESP_DECERR;
    if (sz > MAX_SIZE || bu == BURST_WRAP) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return MEM_AW'((a - BASE_ADDR) >> 2);
  endfunction

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  assign last_beat = (beat_q == len_q);
  assign rd_addr   = (state_q == S_IDLE) ? araddr : next_addr;
  assign rd_word   = mem[word_idx(rd_addr)];
  assign mem_we    = (state_q == S_WR) && wvalid && (resp_q == RESP_OKAY);

  // NOTE: every signal written here gets its default first; a path that
  // skipped one would infer a latch.
  always_comb begin
    state_d     = state_q;
    prefer_rd_d = prefer_rd_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    size_d      = size_q;
    burst_d     = burst_q;
    resp_d      = resp_q;
    wlast_err_d = wlast_err_q;
    rdata_d     = rdata_q;
    arready     = 1'b0;
    awready     = 1'b0;
    rvalid      = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        arready = ~reset & (~awvalid | prefer_rd_q);
        awready = ~reset & (~arvalid | ~prefer_rd_q);
        if (arvalid && arready) begin
          {id_d, addr_d, len_d, size_d, burst_d} = {arid, araddr, arlen, arsize, arburst};
          resp_d      = accept_resp(araddr, arsize, arburst);
          rdata_d     = (resp_d == RESP_OKAY) ? rd_word : '0;
          beat_d      = '0;
          prefer_rd_d = 1'b0;
          state_d     = S_RD;
        end else if (awvalid && awready) begin
          {id_d, addr_d, len_d, size_d, burst_d} = {awid, awaddr, awlen, awsize, awburst};
          resp_d      = accept_resp(awaddr, awsize, awburst);
          wlast_err_d = 1'b0;
          beat_d      = '0;
          prefer_rd_d = 1'b1;
          state_d     = S_WR;
        end
      end
      S_RD: begin
        rvalid = 1'b1;
        if (rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            addr_d  = next_addr;
            rdata_d = (resp_q == RESP_OKAY) ? rd_word : '0;
          end
        end
      end
      S_WR: begin
        wready = 1'b1;
        if (wvalid) begin
          if (wlast != last_beat) wlast_err_d = 1'b1;
          if (last_beat) begin
            state_d = S_WRESP;
          end else begin
            beat_d = beat_q + LEN_W'(1);
            addr_d = next_addr;
          end
        end
      end
      S_WRESP: begin
        bvalid = 1'b1;
        if (bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prefer_rd_q <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      resp_q      <= RESP_OKAY;
      wlast_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      prefer_rd_q <= prefer_rd_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      resp_q      <= resp_d;
      wlast_err_q <= wlast_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; beats committed
  // before a reset remain readable afterwards.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wstrb[i]) mem[word_idx(addr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rid   = id_q;
  assign rdata = rdata_q;
  assign rresp = resp_q;
  assign rlast = (state_q == S_RD) && last_beat;
  assign bid   = id_q;
  assign bresp = (resp_q == RESP_DECERR) ? RESP_DECERR :
                 wlast_err_q             ? RESP_SLVERR : resp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised scoreboard bench for axi_sram_slave: a byte-level memory model
// predicts every R beat and B response; a negedge monitor compares them.
module tb_axi_sram_slave;

  localparam int          MEM_AW = 14;
  localparam int          DEPTH  = 1 << MEM_AW;
  localparam logic [31:0] BASE   = 32'h1c00_0000;

  logic        clk, reset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_sram_slave dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake did not occur within the cycle budget at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu);
    longint unsigned la;
    la = 64'(a);
    if (la < 64'(BASE) || la >= 64'(BASE) + 64'(4 * DEPTH)) return 2'b11;
    if (sz > 3'd2 || bu == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu, input int i);
    if (bu == 2'b00) return a;
    return a + 32'(i) * (32'd1 << sz);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic logic [31:0] mem_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];

  logic [31:0] w_data [16];
  logic [3:0]  w_strb [16];
  time         t_ar, t_aw;
  int          rr_mode = 0;
  int          br_mode = 0;

  // ---------------- response-side ready drivers ----------------
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      bready = (br_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && rvalid) begin
      if (r_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL r_unexpected: got rvalid=1 rid=%0h, expected no read beat at %0t", rid, $time);
      end else begin
        check("rid", 64'(rid), 64'(r_q[0].id));
        check("rdata", 64'(rdata), 64'(r_q[0].data));
        check("rresp", 64'(rresp), 64'(r_q[0].resp));
        check("rlast", 64'(rlast), 64'(r_q[0].last));
        if (rready) void'(r_q.pop_front());
      end
    end
    if (!reset && bvalid) begin
      if (b_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected: got bvalid=1 bid=%0h, expected no response at %0t", bid, $time);
      end else begin
        check("bid", 64'(bid), 64'(b_q[0].id));
        check("bresp", 64'(bresp), 64'(b_q[0].resp));
        if (bready) void'(b_q.pop_front());
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    logic [1:0] resp;
    r_exp_t     e;
    int         cnt;
    resp = model_resp(addr, sz, bu);
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.data = (resp == 2'b00) ? mem_rd(widx(beat_addr(addr, sz, bu, i))) : 32'h0;
      e.resp = resp;
      e.last = (i == int'(len));
      r_q.push_back(e);
    end
    @(posedge clk);
    #1;
    arid = id; araddr = addr; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!arready && cnt < 200);
    if (!arready) begin
      timeout("ar_handshake");
      arvalid = 1'b0;
      r_q.delete();
      return;
    end
    @(posedge clk);
    t_ar = $time;
    #1;
    arvalid = 1'b0;
    check("rvalid_after_ar", 64'(rvalid), 64'd1);
    cnt = 0;
    while (r_q.size() != 0 && cnt < 500) begin @(negedge clk); cnt++; end
    if (r_q.size() != 0) begin
      timeout("r_drain");
      r_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input bit early_last,
                          input int abort_at);
    logic [1:0]  resp;
    bit          proto_err;
    int          cnt, w;
    logic [31:0] word;
    b_exp_t      e;
    resp      = model_resp(addr, sz, bu);
    proto_err = 1'b0;
    @(posedge clk);
    #1;
    awid = id; awaddr = addr; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!awready && cnt < 200);
    if (!awready) begin
      timeout("aw_handshake");
      awvalid = 1'b0;
      return;
    end
    @(posedge clk);
    t_aw = $time;
    #1;
    awvalid = 1'b0;
    check("wready_after_aw", 64'(wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata  = w_data[i];
      wstrb  = w_strb[i];
      wlast  = early_last ? (i == 0) : (i == int'(len));
      wvalid = 1'b1;
      if (i == abort_at) begin
        reset  = 1'b1;
        wvalid = 1'b0;
        wlast  = 1'b0;
        return;
      end
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!wready && cnt < 200);
      if (!wready) begin
        timeout("w_handshake");
        wvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (wlast != (i == int'(len))) proto_err = 1'b1;
      if (resp == 2'b00) begin
        w    = widx(beat_addr(addr, sz, bu, i));
        word = mem_rd(w);
        for (int b = 0; b < 4; b++) if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[w] = word;
      end
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    e.id   = id;
    e.resp = (resp == 2'b11) ? 2'b11 : (proto_err ? 2'b10 : resp);
    b_q.push_back(e);
    check("bvalid_after_wlast", 64'(bvalid), 64'd1);
    cnt = 0;
    while (b_q.size() != 0 && cnt < 500) begin @(negedge clk); cnt++; end
    if (b_q.size() != 0) begin
      timeout("b_drain");
      b_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_arready"}, 64'(arready), 64'd0);
    check({tag, "_awready"}, 64'(awready), 64'd0);
    check({tag, "_wready"}, 64'(wready), 64'd0);
    check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    check({tag, "_bvalid"}, 64'(bvalid), 64'd0);
    check({tag, "_rlast"}, 64'(rlast), 64'd0);
    check({tag, "_rdata_rid"}, 64'({rdata, rid}), 64'd0);
    check({tag, "_bid_resps"}, 64'({bid, rresp, bresp}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  rid_v;
    logic [31:0] addr_v;
    logic [7:0]  len_v;
    logic [2:0]  sz_v;
    logic [1:0]  bu_v;

    reset = 1'b1;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wid, wdata, wstrb, wlast, wvalid} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill words 0..63 so every later read hits written memory.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        w_data[i] = $urandom;
        w_strb[i] = 4'hF;
      end
      do_write(4'(k), BASE + 32'(64 * k), 8'd15, 3'd2, 2'b01, 1'b0, -1);
    end

    // Single beat round trip.
    w_data[0] = 32'hDEAD_BEEF; w_strb[0] = 4'hF;
    do_write(4'h5, BASE, 8'd0, 3'd2, 2'b01, 1'b0, -1);
    do_read(4'h9, BASE, 8'd0, 3'd2, 2'b01);

    // Four-beat INCR burst, read back with rready toggling.
    w_data[0] = 32'h11; w_data[1] = 32'h22; w_data[2] = 32'h33; w_data[3] = 32'h44;
    for (int i = 0; i < 4; i++) w_strb[i] = 4'hF;
    do_write(4'h3, BASE + 32'h10, 8'd3, 3'd2, 2'b01, 1'b0, -1);
    rr_mode = 1;
    do_read(4'h6, BASE + 32'h10, 8'd3, 3'd2, 2'b01);
    rr_mode = 0;

    // Byte strobes over a zeroed word.
    w_data[0] = 32'h0; w_strb[0] = 4'hF;
    do_write(4'h1, BASE + 32'h20, 8'd0, 3'd2, 2'b01, 1'b0, -1);
    w_data[0] = 32'hAABB_CCDD; w_strb[0] = 4'b0101;
    do_write(4'h1, BASE + 32'h20, 8'd0, 3'd2, 2'b01, 1'b0, -1);
    do_read(4'h2, BASE + 32'h20, 8'd0, 3'd2, 2'b01);

    // Decode errors; the write aliases word 0 and must not land.
    do_read(4'hA, 32'h2000_0000, 8'd1, 3'd2, 2'b01);
    w_data[0] = 32'hCAFE_F00D; w_strb[0] = 4'hF;
    do_write(4'hB, 32'h2000_0000, 8'd0, 3'd2, 2'b01, 1'b0, -1);
    do_read(4'hC, BASE, 8'd0, 3'd2, 2'b01);
    do_read(4'hD, BASE - 32'd4, 8'd0, 3'd2, 2'b01);

    // Protocol errors.
    w_data[0] = 32'h1234_5678; w_data[1] = 32'h9ABC_DEF0; w_strb[0] = 4'hF; w_strb[1] = 4'hF;
    do_write(4'h4, BASE + 32'h200, 8'd1, 3'd2, 2'b01, 1'b1, -1);
    do_read(4'h7, BASE, 8'd0, 3'd3, 2'b01);
    do_read(4'h8, BASE, 8'd1, 3'd2, 2'b10);

    // Random traffic with random back-pressure.
    rr_mode = 2;
    br_mode = 2;
    for (int t = 0; t < 60; t++) begin
      rid_v  = 4'($urandom);
      sz_v   = 3'($urandom_range(0, 2));
      bu_v   = 2'($urandom_range(0, 1));
      len_v  = 8'($urandom_range(0, 7));
      addr_v = BASE + 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sz_v = 3'd3;
      if ($urandom_range(0, 9) == 0) bu_v = 2'b10;
      if ($urandom_range(0, 9) == 0) addr_v = 32'h2000_0000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        do_read(rid_v, addr_v, len_v, sz_v, bu_v);
      end else begin
        for (int i = 0; i < 16; i++) begin
          w_data[i] = $urandom;
          w_strb[i] = 4'($urandom_range(0, 15));
        end
        do_write(rid_v, addr_v, len_v, sz_v, bu_v, 1'b0, -1);
      end
    end
    rr_mode = 0;
    br_mode = 0;

    // Reset while beat 2 of a four-beat write is presented.
    for (int i = 0; i < 4; i++) begin
      w_data[i] = $urandom;
      w_strb[i] = 4'hF;
    end
    do_write(4'h7, BASE + 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 2);
    @(negedge clk);
    check_quiet("abort");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    do_read(4'h8, BASE + 32'h100, 8'd1, 3'd2, 2'b01);

    // Simultaneous AR and AW straight out of reset: read wins first.
    reset = 1'b1;
    @(posedge clk);
    #1;
    w_data[0] = $urandom; w_strb[0] = 4'hF;
    fork
      do_read(4'h2, BASE + 32'h80, 8'd1, 3'd2, 2'b01);
      do_write(4'h4, BASE + 32'h40, 8'd0, 3'd2, 2'b01, 1'b0, -1);
      begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("arb_arready", 64'(arready), 64'd1);
        check("arb_awready", 64'(awready), 64'd0);
      end
    join
    check("arb_read_first", 64'(t_ar < t_aw), 64'd1);
    do_read(4'h5, BASE + 32'h40, 8'd0, 3'd2, 2'b01);

    repeat (4) @(posedge clk);
    check("r_queue_drained", 64'(r_q.size()), 64'd0);
    check("b_queue_drained", 64'(b_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
